// File: rtl/i2c_reg_master.sv
// i2c_reg_master: single-master I2C engine for one register write
// (addr+W, reg, data) or one register read (addr+W, reg, Sr, addr+R, data).
// Every bit is four QDIV-long quarters; SDA only changes in quarter 0 and
// is sampled at the end of quarter 3. The repeated START is one released
// 4-quarter bit followed by the same 3 quarters as a plain START.
module i2c_reg_master #(
  parameter int ADDRESS_WIDTH  = 7,
  parameter int REGISTER_WIDTH = 8,
  parameter int I2C_DATA_WIDTH = 8,
  parameter int QDIV           = 63
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      read_write,
  input  logic [ADDRESS_WIDTH-1:0]  device_address,
  input  logic [REGISTER_WIDTH-1:0] register_address,
  input  logic [I2C_DATA_WIDTH-1:0] mosi_data,
  output logic                      busy,
  output logic [I2C_DATA_WIDTH-1:0] miso_data,
  output logic                      nack,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      scl_oe,
  output logic                      sda_oe
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, REG, DATA_WR, RESTART, ADDR_R, DATA_RD, MNACK, STOP
  } state_t;

  state_t                    state, state_nxt;
  logic [15:0]               qcnt;
  logic [1:0]                qtr;
  logic [3:0]                bit_cnt;
  logic [7:0]                tx_sh, rx_sh;
  logic                      rw_q, rd_phase;
  logic [ADDRESS_WIDTH-1:0]  dev_q;
  logic [REGISTER_WIDTH-1:0] reg_q;
  logic [I2C_DATA_WIDTH-1:0] wdata_q;
  logic                      in_bit, is_byte, hold, q_end, last_q, ack_slot;

  // Bit-timed states use four quarters; START and STOP use three.
  assign in_bit   = state inside {ADDR_W, REG, DATA_WR, RESTART, ADDR_R, DATA_RD, MNACK};
  assign is_byte  = state inside {ADDR_W, REG, DATA_WR, ADDR_R};
  // A slave holding SCL low while we release it freezes the quarter timer.
  assign hold     = in_bit && (qtr == 2'd2) && !scl_i;
  assign q_end    = (qcnt == 16'(QDIV - 1)) && !hold;
  assign last_q   = q_end && (qtr == (in_bit ? 2'd3 : 2'd2));
  assign ack_slot = is_byte && (bit_cnt == 4'd8);
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    // NOTE: clocked state always uses non-blocking assignment so every flop samples pre-edge values.
    else        state <= state_nxt;
  end

  // Next-state decode: sequencing advances only at the last quarter of a phase.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = START;
      START:   if (last_q) state_nxt = rd_phase ? ADDR_R : ADDR_W;
      ADDR_W, REG, DATA_WR, ADDR_R:
        if (last_q && ack_slot) begin
          if (sda_i)                 state_nxt = STOP;
          else if (state == ADDR_W)  state_nxt = REG;
          else if (state == REG)     state_nxt = rw_q ? RESTART : DATA_WR;
          else if (state == DATA_WR) state_nxt = STOP;
          else                       state_nxt = DATA_RD;
        end
      RESTART: if (last_q) state_nxt = START;
      DATA_RD: if (last_q && bit_cnt == 4'd7) state_nxt = MNACK;
      MNACK:   if (last_q) state_nxt = STOP;
      STOP:    if (last_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus drive decode: 1 pulls the line low, 0 releases it.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state)
      START: begin
        sda_oe = 1'b1;
        scl_oe = (qtr == 2'd2);
      end
      ADDR_W, REG, DATA_WR, ADDR_R: begin
        scl_oe = (qtr < 2'd2);
        sda_oe = !ack_slot && !tx_sh[7];
      end
      RESTART, DATA_RD, MNACK: scl_oe = (qtr < 2'd2);
      STOP: begin
        scl_oe = (qtr == 2'd0);
        sda_oe = (qtr != 2'd2);
      end
      default: ;
    endcase
  end

  // Request capture, quarter/bit timing, shift registers and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qcnt      <= '0;
      qtr       <= '0;
      bit_cnt   <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      rw_q      <= 1'b0;
      rd_phase  <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      nack      <= 1'b0;
      miso_data <= '0;
    end else if (state == IDLE) begin
      qcnt    <= '0;
      qtr     <= '0;
      bit_cnt <= '0;
      if (enable) begin
        rw_q     <= read_write;
        dev_q    <= device_address;
        reg_q    <= register_address;
        wdata_q  <= mosi_data;
        rd_phase <= 1'b0;
        nack     <= 1'b0;
      end
    end else begin
      if (q_end) begin
        qcnt <= '0;
        qtr  <= last_q ? 2'd0 : qtr + 2'd1;
      end else if (!hold) begin
        qcnt <= qcnt + 16'd1;
      end
      if (last_q) begin
        case (state)
          START: begin
            tx_sh   <= rd_phase ? 8'({dev_q, 1'b1}) : 8'({dev_q, 1'b0});
            bit_cnt <= '0;
          end
          ADDR_W, REG, DATA_WR, ADDR_R: begin
            if (ack_slot) begin
              bit_cnt <= '0;
              if (sda_i) nack  <= 1'b1;
              else       tx_sh <= (state == ADDR_W) ? 8'(reg_q) : 8'(wdata_q);
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              tx_sh   <= {tx_sh[6:0], 1'b0};
            end
          end
          RESTART: rd_phase <= 1'b1;
          DATA_RD: begin
            bit_cnt <= bit_cnt + 4'd1;
            rx_sh   <= {rx_sh[6:0], sda_i};
          end
          STOP: if (rw_q && !nack) miso_data <= I2C_DATA_WIDTH'(rx_sh);
          default: ;
        endcase
      end
    end
  end

endmodule
